debug_sel_scan_ctrl: RTL and testbench

Automatic scan controller for the debug IO selector. It steps a one-hot select mask across a programmed index range of the 64 synchronized debug sources, staying on each source for a programmed number of cycles. While on a source it counts that source's rising edges. At the end of each stay it hands the result downstream through a valid/ready handshake. SEL_MASK_O drives the selector's {H32, L32} mask registers for one DEBUG_O lane, so software can sweep all sources without issuing a register write per step.

---
 rtl/debug_sel_scan_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_debug_sel_scan_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_sel_scan_ctrl.sv
// Automatic scan controller for the debug IO selector: steps a one-hot select
// across an index range, counts rising edges per source and reports each result.
module debug_sel_scan_ctrl #(
  parameter int unsigned C_SRC_WIDTH   = 64,
  parameter int unsigned C_CNT_WIDTH   = 16,
  parameter int unsigned C_DWELL_WIDTH = 32
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     S_AXI_ARESETN,
  input  logic [C_SRC_WIDTH-1:0]   SRC_I,
  input  logic                     START_I,
  input  logic                     STOP_I,
  input  logic                     CONT_I,
  input  logic [5:0]               FIRST_IDX_I,
  input  logic [5:0]               LAST_IDX_I,
  input  logic [C_DWELL_WIDTH-1:0] DWELL_I,
  output logic [C_SRC_WIDTH-1:0]   SEL_MASK_O,
  output logic [5:0]               CUR_IDX_O,
  output logic                     BUSY_O,
  output logic                     DONE_O,
  output logic                     RES_VALID_O,
  input  logic                     RES_READY_I,
  output logic [5:0]               RES_IDX_O,
  output logic [C_CNT_WIDTH-1:0]   RES_CNT_O,
  output logic                     RES_OVF_O
);

  typedef enum logic [1:0] {IDLE, DWELL, REPORT} state_t;

  state_t                   state_q, state_n;
  logic [5:0]               idx_q, idx_n;
  logic [5:0]               first_q, first_n;
  logic [5:0]               last_q, last_n;
  logic [C_DWELL_WIDTH-1:0] dwell_q, dwell_n;
  logic                     cont_q, cont_n;
  logic [C_DWELL_WIDTH-1:0] dcnt_q, dcnt_n;
  logic [C_CNT_WIDTH-1:0]   ecnt_q, ecnt_n;
  logic                     sat_q, sat_n;
  logic                     prev_q, prev_n;
  logic [C_SRC_WIDTH-1:0]   mask_q, mask_n;
  logic                     busy_q, busy_n;
  logic                     done_q, done_n;
  logic                     rv_q, rv_n;
  logic [5:0]               ridx_q, ridx_n;
  logic [C_CNT_WIDTH-1:0]   rcnt_q, rcnt_n;
  logic                     rovf_q, rovf_n;

  logic                     src_bit;
  logic                     rise;
  logic [C_CNT_WIDTH-1:0]   cnt_upd;
  logic                     sat_upd;
  logic [5:0]               idx_next;

  assign src_bit = SRC_I[idx_q];

  always_comb begin
    state_n  = state_q;
    idx_n    = idx_q;
    first_n  = first_q;
    last_n   = last_q;
    dwell_n  = dwell_q;
    cont_n   = cont_q;
    dcnt_n   = dcnt_q;
    ecnt_n   = ecnt_q;
    sat_n    = sat_q;
    prev_n   = prev_q;
    mask_n   = mask_q;
    busy_n   = busy_q;
    done_n   = 1'b0;
    rv_n     = rv_q;
    ridx_n   = ridx_q;
    rcnt_n   = rcnt_q;
    rovf_n   = rovf_q;
    rise     = 1'b0;
    cnt_upd  = ecnt_q;
    sat_upd  = sat_q;
    idx_next = idx_q + 6'd1;

    case (state_q)
      IDLE: begin
        if (START_I && !STOP_I) begin
          first_n = FIRST_IDX_I;
          last_n  = LAST_IDX_I;
          dwell_n = (DWELL_I == '0) ? C_DWELL_WIDTH'(1) : DWELL_I;
          cont_n  = CONT_I;
          idx_n   = FIRST_IDX_I;
          mask_n  = C_SRC_WIDTH'(1) << FIRST_IDX_I;
          busy_n  = 1'b1;
          dcnt_n  = '0;
          ecnt_n  = '0;
          sat_n   = 1'b0;
          state_n = DWELL;
        end
      end

      DWELL: begin
        // the entry cycle (dcnt_q == 0) only seeds prev, so an edge already present is not counted
        rise = (dcnt_q != '0) && src_bit && !prev_q;
        if (rise && (ecnt_q != '1)) begin
          cnt_upd = ecnt_q + C_CNT_WIDTH'(1);
        end
        if (cnt_upd == '1) begin
          sat_upd = 1'b1;
        end
        ecnt_n = cnt_upd;
        sat_n  = sat_upd;
        prev_n = src_bit;
        dcnt_n = dcnt_q + C_DWELL_WIDTH'(1);
        if (dcnt_q == dwell_q - C_DWELL_WIDTH'(1)) begin
          state_n = REPORT;
          rv_n    = 1'b1;
          ridx_n  = idx_q;
          rcnt_n  = cnt_upd;
          rovf_n  = sat_upd;
        end
      end

      REPORT: begin
        if (RES_READY_I) begin
          rv_n = 1'b0;
          if ((idx_q == last_q) && !cont_q) begin
            state_n = IDLE;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            mask_n  = '0;
          end else begin
            if (idx_q == last_q) begin
              idx_next = first_q;
            end
            idx_n   = idx_next;
            mask_n  = C_SRC_WIDTH'(1) << idx_next;
            dcnt_n  = '0;
            ecnt_n  = '0;
            sat_n   = 1'b0;
            state_n = DWELL;
          end
        end
      end

      default: state_n = IDLE;
    endcase

    // abort overrides every transition above, including a pending handshake
    if (STOP_I && (state_q != IDLE)) begin
      state_n = IDLE;
      rv_n    = 1'b0;
      mask_n  = '0;
      busy_n  = 1'b0;
      done_n  = 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= IDLE;
      idx_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
      dwell_q <= '0;
      cont_q  <= 1'b0;
      dcnt_q  <= '0;
      ecnt_q  <= '0;
      sat_q   <= 1'b0;
      prev_q  <= 1'b0;
      mask_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rv_q    <= 1'b0;
      ridx_q  <= '0;
      rcnt_q  <= '0;
      rovf_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      first_q <= first_n;
      last_q  <= last_n;
      dwell_q <= dwell_n;
      cont_q  <= cont_n;
      dcnt_q  <= dcnt_n;
      ecnt_q  <= ecnt_n;
      sat_q   <= sat_n;
      prev_q  <= prev_n;
      mask_q  <= mask_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      rv_q    <= rv_n;
      ridx_q  <= ridx_n;
      rcnt_q  <= rcnt_n;
      rovf_q  <= rovf_n;
    end
  end

  assign SEL_MASK_O  = mask_q;
  assign CUR_IDX_O   = idx_q;
  assign BUSY_O      = busy_q;
  assign DONE_O      = done_q;
  assign RES_VALID_O = rv_q;
  assign RES_IDX_O   = ridx_q;
  assign RES_CNT_O   = rcnt_q;
  assign RES_OVF_O   = rovf_q;

endmodule

// File: tb/tb_debug_sel_scan_ctrl.sv
// Self-checking bench for debug_sel_scan_ctrl; a narrow-counter second instance
// shares all inputs so counter saturation is reachable in a short run.
module tb_debug_sel_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] SRC_I = '0;
  logic        START_I = 1'b0, STOP_I = 1'b0, CONT_I = 1'b0, RES_READY_I = 1'b1;
  logic [5:0]  FIRST_IDX_I = '0, LAST_IDX_I = '0;
  logic [31:0] DWELL_I = '0;

  logic [63:0] SEL_MASK_O, s_mask;
  logic [5:0]  CUR_IDX_O, RES_IDX_O, s_cur, s_ridx;
  logic        BUSY_O, DONE_O, RES_VALID_O, RES_OVF_O;
  logic        s_busy, s_done, s_rv, s_ovf;
  logic [15:0] RES_CNT_O;
  logic [5:0]  s_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  debug_sel_scan_ctrl u_dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .SRC_I(SRC_I),
    .START_I(START_I), .STOP_I(STOP_I), .CONT_I(CONT_I),
    .FIRST_IDX_I(FIRST_IDX_I), .LAST_IDX_I(LAST_IDX_I), .DWELL_I(DWELL_I),
    .SEL_MASK_O(SEL_MASK_O), .CUR_IDX_O(CUR_IDX_O), .BUSY_O(BUSY_O), .DONE_O(DONE_O),
    .RES_VALID_O(RES_VALID_O), .RES_READY_I(RES_READY_I), .RES_IDX_O(RES_IDX_O),
    .RES_CNT_O(RES_CNT_O), .RES_OVF_O(RES_OVF_O)
  );

  debug_sel_scan_ctrl #(.C_CNT_WIDTH(6)) u_sat (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .SRC_I(SRC_I),
    .START_I(START_I), .STOP_I(STOP_I), .CONT_I(CONT_I),
    .FIRST_IDX_I(FIRST_IDX_I), .LAST_IDX_I(LAST_IDX_I), .DWELL_I(DWELL_I),
    .SEL_MASK_O(s_mask), .CUR_IDX_O(s_cur), .BUSY_O(s_busy), .DONE_O(s_done),
    .RES_VALID_O(s_rv), .RES_READY_I(RES_READY_I), .RES_IDX_O(s_ridx),
    .RES_CNT_O(s_cnt), .RES_OVF_O(s_ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // 0: random, 1: one-cycle pulse on bit 3 every third cycle, 2: toggle all, 3: quiet
  task automatic drive_src(input int mode);
    case (mode)
      0: SRC_I = {$urandom, $urandom};
      1: SRC_I = (cyc % 3 == 0) ? 64'h8 : 64'h0;
      2: SRC_I = ~SRC_I;
      default: SRC_I = '0;
    endcase
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({SEL_MASK_O, CUR_IDX_O, BUSY_O, DONE_O, RES_VALID_O, RES_IDX_O, RES_CNT_O, RES_OVF_O} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got mask=%h idx=%0d busy=%b done=%b rv=%b ridx=%0d cnt=%0d ovf=%b required all 0",
               SEL_MASK_O, CUR_IDX_O, BUSY_O, DONE_O, RES_VALID_O, RES_IDX_O, RES_CNT_O, RES_OVF_O);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // Runs one scan from IDLE. n_res == 0 means one full pass; otherwise n_res results
  // are taken and the call returns in the entry cycle of the following DWELL.
  task automatic test_scan(input string nm, input int first, input int last, input int dwell,
                           input bit cont, input int stall, input int mode, input int n_res);
    int seq[$];
    int dw, i, total;
    dw = (dwell == 0) ? 1 : dwell;
    i = first;
    forever begin
      seq.push_back(i);
      if (i == last) break;
      i = (i + 1) % 64;
    end
    total = (n_res == 0) ? seq.size() : n_res;

    FIRST_IDX_I = first[5:0]; LAST_IDX_I = last[5:0]; DWELL_I = dwell; CONT_I = cont;
    START_I = 1'b1; RES_READY_I = 1'b1;
    drive_src(mode);
    step();

    for (int r = 0; r < total; r++) begin
      int idx, cnt;
      logic [63:0] emask;
      logic [15:0] ecnt;
      logic [5:0]  escnt;
      bit q[$];
      idx = seq[r % seq.size()];
      emask = 64'h1 << idx;
      for (int d = 0; d < dw; d++) begin
        n_cmp++;
        if ({SEL_MASK_O, CUR_IDX_O, BUSY_O, RES_VALID_O, DONE_O} !== {emask, idx[5:0], 3'b100}) begin
          n_bad++;
          $display("FAIL %s dwell_outputs r=%0d d=%0d: got mask=%h idx=%0d busy=%b rv=%b done=%b required mask=%h idx=%0d busy=1 rv=0 done=0",
                   nm, r, d, SEL_MASK_O, CUR_IDX_O, BUSY_O, RES_VALID_O, DONE_O, emask, idx);
        end
        // config and START wiggle mid-scan and must be ignored
        FIRST_IDX_I = 6'($urandom); LAST_IDX_I = 6'($urandom); DWELL_I = $urandom % 8; CONT_I = 1'($urandom);
        START_I = ($urandom % 4 == 0);
        drive_src(mode);
        q.push_back(SRC_I[idx]);
        step();
      end
      cnt = 0;
      for (int j = 1; j < q.size(); j++) if (q[j] && !q[j-1]) cnt++;
      ecnt  = (cnt >= 65535) ? 16'hFFFF : 16'(cnt);
      escnt = (cnt >= 63) ? 6'h3F : 6'(cnt);
      for (int s = 0; s <= stall; s++) begin
        n_cmp++;
        if ({RES_VALID_O, RES_IDX_O, RES_CNT_O, RES_OVF_O, SEL_MASK_O, BUSY_O} !==
            {1'b1, idx[5:0], ecnt, (cnt >= 65535), emask, 1'b1}) begin
          n_bad++;
          $display("FAIL %s result r=%0d s=%0d: got rv=%b idx=%0d cnt=%0d ovf=%b mask=%h required rv=1 idx=%0d cnt=%0d ovf=%b mask=%h",
                   nm, r, s, RES_VALID_O, RES_IDX_O, RES_CNT_O, RES_OVF_O, SEL_MASK_O, idx, ecnt, (cnt >= 65535), emask);
        end
        n_cmp++;
        if ({s_rv, s_ridx, s_cnt, s_ovf} !== {1'b1, idx[5:0], escnt, (cnt >= 63)}) begin
          n_bad++;
          $display("FAIL %s sat_result r=%0d: got rv=%b idx=%0d cnt=%0d ovf=%b required rv=1 idx=%0d cnt=%0d ovf=%b",
                   nm, r, s_rv, s_ridx, s_cnt, s_ovf, idx, escnt, (cnt >= 63));
        end
        RES_READY_I = (s == stall);
        drive_src(mode);
        step();
      end
      START_I = 1'b0;
      if (!cont && (r == total - 1)) begin
        n_cmp++;
        if ({DONE_O, BUSY_O, RES_VALID_O, SEL_MASK_O} !== {3'b100, 64'h0}) begin
          n_bad++;
          $display("FAIL %s done: got done=%b busy=%b rv=%b mask=%h required done=1 busy=0 rv=0 mask=0",
                   nm, DONE_O, BUSY_O, RES_VALID_O, SEL_MASK_O);
        end
        step();
        n_cmp++;
        if ({DONE_O, BUSY_O} !== 2'b00) begin
          n_bad++;
          $display("FAIL %s done_pulse: got done=%b busy=%b required 0 0", nm, DONE_O, BUSY_O);
        end
      end
    end
    START_I = 1'b0;
  endtask

  task automatic test_basic();
    test_scan("basic", 2, 4, 10, 1'b0, 0, 1, 0);
  endtask

  task automatic test_wrap();
    test_scan("wrap", 62, 1, 1, 1'b0, 0, 0, 0);
    test_scan("dwell0", 40, 41, 0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_saturation();
    SRC_I = '0;
    test_scan("sat", 7, 7, 150, 1'b0, 0, 2, 0);
  endtask

  task automatic test_backpressure();
    test_scan("bp", 10, 12, 5, 1'b0, 50, 0, 0);
  endtask

  task automatic test_idle_controls();
    STOP_I = 1'b1;
    step();
    STOP_I = 1'b0;
    n_cmp++;
    if ({BUSY_O, SEL_MASK_O, DONE_O} !== '0) begin
      n_bad++;
      $display("FAIL stop_idle: got busy=%b mask=%h done=%b required 0", BUSY_O, SEL_MASK_O, DONE_O);
    end
    FIRST_IDX_I = 6'd9; LAST_IDX_I = 6'd9; DWELL_I = 32'd3;
    START_I = 1'b1; STOP_I = 1'b1;
    step();
    START_I = 1'b0; STOP_I = 1'b0;
    n_cmp++;
    if ({BUSY_O, SEL_MASK_O} !== '0) begin
      n_bad++;
      $display("FAIL start_stop_idle: got busy=%b mask=%h required busy=0 mask=0", BUSY_O, SEL_MASK_O);
    end
  endtask

  task automatic test_stop();
    test_scan("cont", 5, 5, 4, 1'b1, 0, 0, 3);
    drive_src(0);
    step();
    STOP_I = 1'b1;
    step();
    STOP_I = 1'b0;
    n_cmp++;
    if ({BUSY_O, SEL_MASK_O, RES_VALID_O, DONE_O} !== '0) begin
      n_bad++;
      $display("FAIL stop_dwell: got busy=%b mask=%h rv=%b done=%b required 0", BUSY_O, SEL_MASK_O, RES_VALID_O, DONE_O);
    end
    for (int k = 0; k < 10; k++) begin
      drive_src(0);
      step();
      n_cmp++;
      if ({BUSY_O, RES_VALID_O, DONE_O} !== 3'b000) begin
        n_bad++;
        $display("FAIL stop_quiet k=%0d: got busy=%b rv=%b done=%b required 0", k, BUSY_O, RES_VALID_O, DONE_O);
      end
    end
    FIRST_IDX_I = 6'd9; LAST_IDX_I = 6'd9; DWELL_I = 32'd2; CONT_I = 1'b0;
    START_I = 1'b1; RES_READY_I = 1'b0;
    step();
    START_I = 1'b0;
    step();
    step();
    n_cmp++;
    if (RES_VALID_O !== 1'b1) begin
      n_bad++;
      $display("FAIL stop_report_pre: got rv=%b required 1", RES_VALID_O);
    end
    STOP_I = 1'b1;
    step();
    STOP_I = 1'b0;
    RES_READY_I = 1'b1;
    n_cmp++;
    if ({BUSY_O, SEL_MASK_O, RES_VALID_O, DONE_O} !== '0) begin
      n_bad++;
      $display("FAIL stop_report: got busy=%b mask=%h rv=%b done=%b required 0", BUSY_O, SEL_MASK_O, RES_VALID_O, DONE_O);
    end
    step();
  endtask

  task automatic test_async_reset();
    FIRST_IDX_I = 6'd30; LAST_IDX_I = 6'd33; DWELL_I = 32'd3; CONT_I = 1'b0;
    START_I = 1'b1; RES_READY_I = 1'b0;
    step();
    START_I = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_src(2);
      step();
    end
    DWELL_I = 32'd20;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({SEL_MASK_O, CUR_IDX_O, BUSY_O, DONE_O, RES_VALID_O, RES_IDX_O, RES_CNT_O, RES_OVF_O} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got mask=%h idx=%0d busy=%b rv=%b ridx=%0d cnt=%0d required all 0",
               SEL_MASK_O, CUR_IDX_O, BUSY_O, RES_VALID_O, RES_IDX_O, RES_CNT_O);
    end
    @(negedge clk);
    rst_n = 1'b1;
    RES_READY_I = 1'b1;
    step();
    test_scan("post_reset", 30, 33, 4, 1'b0, 0, 3, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      int f;
      f = $urandom % 64;
      test_scan("rand", f, (f + $urandom % 4) % 64, $urandom % 6, 1'b0, $urandom % 3, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_saturation();
    test_backpressure();
    test_idle_controls();
    test_stop();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
